// File: rtl/status_register_unit.sv
// Status register unit: holds the architectural {N,Z,C,V} flags, tracks how
// many flag-setting instructions are in flight, and raises a hazard when an
// ID-stage instruction reads the flags while a setter is still in flight.
// Optional feature macro: STATUS_SHADOW_EN adds a save/restore shadow copy of
// the flags (ports save, restore, shadow_reg).
module status_register_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_issue,
   input  logic       id_set_flags,
   input  logic       id_uses_flags,
   input  logic       exe_valid,
   input  logic       exe_s,
   input  logic       exe_cond_pass,
   input  logic [3:0] alu_nzcv,
   input  logic       msr_we,
   input  logic [3:0] msr_data,
   input  logic       flush,
   input  logic       freeze,
`ifdef STATUS_SHADOW_EN
   input  logic       save,
   input  logic       restore,
   output logic [3:0] shadow_reg,
`endif
   output logic [3:0] status_reg,
   output logic       flag_hazard,
   output logic [1:0] pending_cnt,
   output logic       err_ovf,
   output logic       err_udf
);

   logic [3:0] r_statusReg;
   logic [1:0] r_pendingCnt;
   logic       r_errOvf;
   logic       r_errUdf;
   logic       w_aluUpdate;
   logic       w_incEvent;
   logic       w_decEvent;

   // A flag setter enters the window at issue and leaves it when it reaches
   // EXE, whether or not its condition passed; only a passing one writes.
   assign w_aluUpdate = exe_valid & exe_s & exe_cond_pass;
   assign w_incEvent  = id_issue & id_set_flags;
   assign w_decEvent  = exe_valid & exe_s;

`ifdef STATUS_SHADOW_EN
   logic [3:0] r_shadowReg;

   // Flags and shadow copy; restore wins over every other write, and save
   // captures the pre-update flags so save+restore together is a swap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_statusReg <= 4'b0000;
         r_shadowReg <= 4'b0000;
      end else if (!freeze) begin
         if (restore) begin
            r_statusReg <= r_shadowReg;
         end else if (msr_we) begin
            r_statusReg <= msr_data;
         end else if (w_aluUpdate) begin
            r_statusReg <= alu_nzcv;
         end
         if (save) begin
            r_shadowReg <= r_statusReg;
         end
      end
   end

   assign shadow_reg = r_shadowReg;
`else
   // Flags register; a direct write takes precedence over the ALU result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_statusReg <= 4'b0000;
      end else if (!freeze) begin
         if (msr_we) begin
            r_statusReg <= msr_data;
         end else if (w_aluUpdate) begin
            r_statusReg <= alu_nzcv;
         end
      end
   end
`endif

   // In-flight setter count, saturating at 0 and 3 with sticky error flags;
   // flush empties the pipeline so it clears the count outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pendingCnt <= 2'd0;
         r_errOvf     <= 1'b0;
         r_errUdf     <= 1'b0;
      end else if (!freeze) begin
         if (flush) begin
            r_pendingCnt <= 2'd0;
         end else if (w_incEvent && !w_decEvent) begin
            if (r_pendingCnt == 2'd3) begin
               r_errOvf <= 1'b1;
            end else begin
               r_pendingCnt <= r_pendingCnt + 2'd1;
            end
         end else if (w_decEvent && !w_incEvent) begin
            if (r_pendingCnt == 2'd0) begin
               r_errUdf <= 1'b1;
            end else begin
               r_pendingCnt <= r_pendingCnt - 2'd1;
            end
         end
      end
   end

   assign status_reg  = r_statusReg;
   assign pending_cnt = r_pendingCnt;
   assign err_ovf     = r_errOvf;
   assign err_udf     = r_errUdf;
   assign flag_hazard = id_uses_flags & (r_pendingCnt != 2'd0);

endmodule

// File: tb/tb_status_register_unit.sv
// Testbench for status_register_unit: directed scenarios plus randomized
// traffic checked against a behavioural flag/counter model.
// Shadow save/restore scenarios are exercised when STATUS_SHADOW_EN is defined.
module tb_status_register_unit;

   logic       clk;
   logic       rst;
   logic       id_issue;
   logic       id_set_flags;
   logic       id_uses_flags;
   logic       exe_valid;
   logic       exe_s;
   logic       exe_cond_pass;
   logic [3:0] alu_nzcv;
   logic       msr_we;
   logic [3:0] msr_data;
   logic       flush;
   logic       freeze;
   logic       save;
   logic       restore;
   logic [3:0] status_reg;
   logic       flag_hazard;
   logic [1:0] pending_cnt;
   logic       err_ovf;
   logic       err_udf;
`ifdef STATUS_SHADOW_EN
   logic [3:0] shadow_reg;
`endif

   int checks;
   int errors;

   logic [3:0] mFlags;
   logic [3:0] mShadow;
   int         mCnt;
   bit         mOvf;
   bit         mUdf;

   status_register_unit dut (
      .clk           (clk),
      .rst           (rst),
      .id_issue      (id_issue),
      .id_set_flags  (id_set_flags),
      .id_uses_flags (id_uses_flags),
      .exe_valid     (exe_valid),
      .exe_s         (exe_s),
      .exe_cond_pass (exe_cond_pass),
      .alu_nzcv      (alu_nzcv),
      .msr_we        (msr_we),
      .msr_data      (msr_data),
      .flush         (flush),
      .freeze        (freeze),
`ifdef STATUS_SHADOW_EN
      .save          (save),
      .restore       (restore),
      .shadow_reg    (shadow_reg),
`endif
      .status_reg    (status_reg),
      .flag_hazard   (flag_hazard),
      .pending_cnt   (pending_cnt),
      .err_ovf       (err_ovf),
      .err_udf       (err_udf)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Return every stimulus input to its idle value
   task automatic clearInputs();
      id_issue = 0; id_set_flags = 0; id_uses_flags = 0;
      exe_valid = 0; exe_s = 0; exe_cond_pass = 0; alu_nzcv = 4'h0;
      msr_we = 0; msr_data = 4'h0; flush = 0; freeze = 0;
      save = 0; restore = 0;
   endtask

   // Behavioural model: advance one clock edge from the current inputs
   task automatic modelStep();
      logic [3:0] oldFlags;
      int         inc;
      int         dec;
      int         n;
      if (!freeze) begin
         oldFlags = mFlags;
         inc = (id_issue && id_set_flags) ? 1 : 0;
         dec = (exe_valid && exe_s) ? 1 : 0;
`ifdef STATUS_SHADOW_EN
         if (restore) mFlags = mShadow;
         else if (msr_we) mFlags = msr_data;
         else if (exe_valid && exe_s && exe_cond_pass) mFlags = alu_nzcv;
         if (save) mShadow = oldFlags;
`else
         if (msr_we) mFlags = msr_data;
         else if (exe_valid && exe_s && exe_cond_pass) mFlags = alu_nzcv;
`endif
         if (flush) begin
            mCnt = 0;
         end else begin
            n = mCnt + inc - dec;
            if (n > 3) begin mOvf = 1; n = 3; end
            if (n < 0) begin mUdf = 1; n = 0; end
            mCnt = n;
         end
      end
   endtask

   task automatic modelReset();
      mFlags = 4'h0; mShadow = 4'h0; mCnt = 0; mOvf = 0; mUdf = 0;
   endtask

   // Advance the model and the DUT by one edge, then settle for sampling
   task automatic applyStimulus();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across one edge and release it just after
   task automatic doReset();
      rst = 1'b1;
      clearInputs();
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Reset values and first write right after release
   task automatic test_reset();
      doReset();
      checks++;
      if (status_reg !== 4'h0 || pending_cnt !== 2'd0 || err_ovf !== 1'b0 || err_udf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state got st=%h cnt=%0d ovf=%b udf=%b expected 0/0/0/0",
                  status_reg, pending_cnt, err_ovf, err_udf);
      end
      msr_we = 1; msr_data = 4'b0101;
      applyStimulus();
      msr_we = 0;
      checks++;
      if (status_reg !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL first_write got %b expected 0101", status_reg);
      end
   endtask

   // ALU update loads flags; a failed condition holds them but still retires
   task automatic test_alu_update();
      doReset();
      exe_valid = 1; exe_s = 1; exe_cond_pass = 1; alu_nzcv = 4'b0100;
      modelStep();
      @(posedge clk);
      checks++;
      if (status_reg !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL no_bypass got %b expected 0000", status_reg);
      end
      #1;
      checks++;
      if (status_reg !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL alu_update got %b expected 0100", status_reg);
      end
      clearInputs();
      id_issue = 1; id_set_flags = 1;
      applyStimulus();
      clearInputs();
      exe_valid = 1; exe_s = 1; exe_cond_pass = 0; alu_nzcv = 4'b1000;
      applyStimulus();
      clearInputs();
      checks++;
      if (status_reg !== 4'b0100 || pending_cnt !== 2'd0) begin
         errors++;
         $display("[TB] FAIL cond_fail_hold got st=%b cnt=%0d expected 0100/0", status_reg, pending_cnt);
      end
   endtask

   // Direct write beats a same-edge ALU update
   task automatic test_msr_priority();
      msr_we = 1; msr_data = 4'b0011;
      exe_valid = 1; exe_s = 1; exe_cond_pass = 1; alu_nzcv = 4'b1100;
      id_issue = 1; id_set_flags = 1;
      applyStimulus();
      clearInputs();
      checks++;
      if (status_reg !== 4'b0011) begin
         errors++;
         $display("[TB] FAIL msr_priority got %b expected 0011", status_reg);
      end
   endtask

   // Saturation at both ends of the counter and the hazard output
   task automatic test_counter_range();
      doReset();
      id_issue = 1; id_set_flags = 1;
      for (int i = 0; i < 4; i++) applyStimulus();
      clearInputs();
      checks++;
      if (pending_cnt !== 2'd3 || err_ovf !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overflow got cnt=%0d ovf=%b expected 3/1", pending_cnt, err_ovf);
      end
      id_uses_flags = 1;
      #1;
      checks++;
      if (flag_hazard !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hazard_set got %b expected 1", flag_hazard);
      end
      exe_valid = 1; exe_s = 1;
      for (int i = 0; i < 3; i++) applyStimulus();
      exe_valid = 0; exe_s = 0;
      #1;
      checks++;
      if (pending_cnt !== 2'd0 || flag_hazard !== 1'b0 || err_udf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain got cnt=%0d haz=%b udf=%b expected 0/0/0", pending_cnt, flag_hazard, err_udf);
      end
      exe_valid = 1; exe_s = 1;
      applyStimulus();
      clearInputs();
      checks++;
      if (pending_cnt !== 2'd0 || err_udf !== 1'b1 || err_ovf !== 1'b1) begin
         errors++;
         $display("[TB] FAIL underflow got cnt=%0d udf=%b ovf=%b expected 0/1/1", pending_cnt, err_udf, err_ovf);
      end
   endtask

   // Freeze holds everything; flush wins over a same-edge issue
   task automatic test_freeze_flush();
      doReset();
      id_issue = 1; id_set_flags = 1;
      applyStimulus();
      applyStimulus();
      clearInputs();
      freeze = 1; exe_valid = 1; exe_s = 1; exe_cond_pass = 1; alu_nzcv = 4'b1111;
      id_uses_flags = 1;
      applyStimulus();
      checks++;
      if (status_reg !== 4'b0000 || pending_cnt !== 2'd2 || flag_hazard !== 1'b1) begin
         errors++;
         $display("[TB] FAIL freeze_hold got st=%b cnt=%0d haz=%b expected 0000/2/1",
                  status_reg, pending_cnt, flag_hazard);
      end
      clearInputs();
      flush = 1; id_issue = 1; id_set_flags = 1;
      applyStimulus();
      clearInputs();
      checks++;
      if (pending_cnt !== 2'd0 || status_reg !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL flush got cnt=%0d st=%b expected 0/0000", pending_cnt, status_reg);
      end
   endtask

   // Reset asserted between edges clears the flags immediately
   task automatic test_async_reset();
      msr_we = 1; msr_data = 4'b1010;
      applyStimulus();
      clearInputs();
      exe_valid = 1; exe_s = 1; exe_cond_pass = 1; alu_nzcv = 4'b0111;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (status_reg !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL async_reset got %b expected 0000", status_reg);
      end
      modelReset();
      @(posedge clk);
      #1;
      checks++;
      if (status_reg !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_discard got %b expected 0000", status_reg);
      end
      rst = 1'b0;
      clearInputs();
   endtask

`ifdef STATUS_SHADOW_EN
   // Save, overwrite, restore, then swap
   task automatic test_shadow();
      doReset();
      msr_we = 1; msr_data = 4'b0110;
      applyStimulus();
      clearInputs();
      save = 1;
      applyStimulus();
      clearInputs();
      msr_we = 1; msr_data = 4'b1001;
      applyStimulus();
      clearInputs();
      restore = 1;
      applyStimulus();
      clearInputs();
      checks++;
      if (status_reg !== 4'b0110) begin
         errors++;
         $display("[TB] FAIL restore got %b expected 0110", status_reg);
      end
      msr_we = 1; msr_data = 4'b0001;
      applyStimulus();
      clearInputs();
      save = 1; restore = 1;
      applyStimulus();
      clearInputs();
      checks++;
      if (status_reg !== 4'b0110 || shadow_reg !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL swap got st=%b sh=%b expected 0110/0001", status_reg, shadow_reg);
      end
   endtask
`endif

   // Random traffic compared with the model after every edge
   task automatic test_random();
      doReset();
      for (int i = 0; i < 400; i++) begin
         id_issue      = 1'($urandom_range(0, 1));
         id_set_flags  = 1'($urandom_range(0, 1));
         id_uses_flags = 1'($urandom_range(0, 1));
         exe_valid     = 1'($urandom_range(0, 1));
         exe_s         = 1'($urandom_range(0, 1));
         exe_cond_pass = 1'($urandom_range(0, 1));
         alu_nzcv      = 4'($urandom);
         msr_we        = ($urandom_range(0, 7) == 0);
         msr_data      = 4'($urandom);
         flush         = ($urandom_range(0, 15) == 0);
         freeze        = ($urandom_range(0, 7) == 0);
`ifdef STATUS_SHADOW_EN
         save          = ($urandom_range(0, 7) == 0);
         restore       = ($urandom_range(0, 7) == 0);
`endif
         applyStimulus();
         checks++;
         if (status_reg !== mFlags || pending_cnt !== 2'(mCnt) || err_ovf !== mOvf || err_udf !== mUdf
             || flag_hazard !== (id_uses_flags && mCnt != 0)) begin
            errors++;
            $display("[TB] FAIL random[%0d] got st=%b cnt=%0d ovf=%b udf=%b haz=%b expected st=%b cnt=%0d ovf=%b udf=%b haz=%b",
                     i, status_reg, pending_cnt, err_ovf, err_udf, flag_hazard,
                     mFlags, mCnt, mOvf, mUdf, (id_uses_flags && mCnt != 0));
         end
`ifdef STATUS_SHADOW_EN
         checks++;
         if (shadow_reg !== mShadow) begin
            errors++;
            $display("[TB] FAIL random_shadow[%0d] got %b expected %b", i, shadow_reg, mShadow);
         end
`endif
      end
      clearInputs();
   endtask

   // Scenario sequence and summary
   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      clearInputs();
      modelReset();
      #1;
      test_reset();
      test_alu_update();
      test_msr_priority();
      test_counter_range();
      test_freeze_flush();
      test_async_reset();
`ifdef STATUS_SHADOW_EN
      test_shadow();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/status_register_unit.md
STATUS_REGISTER_UNIT -- requirements
Module: status_register_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, asynchronous, active-high reset.
REQ-002 SHALL provide the following inputs:
- id_issue in 1: instruction leaves ID this cycle.
- id_set_flags in 1: the ID instruction has S=1.
- id_uses_flags in 1: the ID instruction's cond is not AL (4'b1110).
- exe_valid in 1: the EXE stage holds a live instruction.
- exe_s in 1: the EXE instruction has S=1.
- exe_cond_pass in 1: condition-check result for the EXE instruction.
- alu_nzcv in 4: ALU flags {N,Z,C,V}.
- msr_we in 1: direct flag write strobe.
- msr_data in 4: direct flag write value {N,Z,C,V}.
- flush in 1: pipeline flush.
- freeze in 1: global stall.
REQ-003 SHALL provide the following outputs:
- status_reg out 4: architectural flags {N,Z,C,V}, bit 3 = N.
- flag_hazard out 1: the ID instruction must stall.
- pending_cnt out 2: number of in-flight flag setters.
- err_ovf out 1: sticky pending-count overflow.
- err_udf out 1: sticky pending-count underflow.

Function
REQ-004 status_reg SHALL update only on the rising edge of clk, and only when freeze=0; when freeze=1 all state SHALL hold.
REQ-005 Write priority per edge SHALL be, highest first: restore (REQ-016), msr_we (load msr_data), ALU update (load alu_nzcv); otherwise status_reg SHALL hold.
REQ-006 ALU update SHALL occur iff exe_valid=1, exe_s=1 and exe_cond_pass=1.
REQ-007 New flags SHALL be visible on status_reg in the cycle after the write edge (1-cycle latency); there SHALL be no combinational bypass from alu_nzcv to status_reg.
REQ-008 Increment event: id_issue=1 and id_set_flags=1. Decrement event: exe_valid=1 and exe_s=1, regardless of exe_cond_pass.
REQ-009 pending_cnt SHALL count per edge with freeze=0 as follows:
- increment only: +1;
- decrement only: -1;
- both events: unchanged;
- neither event: unchanged.
REQ-010 An increment at pending_cnt=3 SHALL leave pending_cnt at 3 and set err_ovf.
REQ-011 A decrement at pending_cnt=0 SHALL leave pending_cnt at 0 and set err_udf.
REQ-012 flush=1 (with freeze=0) SHALL clear pending_cnt to 0 on that edge and override any same-edge increment or decrement; flush SHALL NOT alter status_reg.
REQ-013 flag_hazard SHALL be combinational: id_uses_flags AND (pending_cnt != 0). It SHALL NOT depend on flush or freeze.
REQ-014 err_ovf and err_udf SHALL remain set until reset.

Reset
REQ-015 On rst=1, regardless of clk, the block SHALL force:
- status_reg = 4'b0000;
- pending_cnt = 0;
- err_ovf = 0 and err_udf = 0;
- shadow_reg = 4'b0000 when present.
Reset asserted mid-stall or mid-update SHALL discard the pending write. The first write SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-016 Macro STATUS_SHADOW_EN.
- When defined, the block SHALL add these ports:
  - save in 1;
  - restore in 1;
  - shadow_reg out 4.
- On an edge with freeze=0:
  - save=1 SHALL copy the current status_reg (pre-update value) into shadow_reg;
  - restore=1 SHALL load shadow_reg into status_reg at top priority;
  - save and restore both =1 SHALL swap status_reg and shadow_reg.
- When STATUS_SHADOW_EN is undefined, these ports and the shadow_reg storage SHALL NOT exist, and priority SHALL start at msr_we.

Verification
REQ-017 Directed scenarios:
- ALU update and hold: after reset, exe_valid=1, exe_s=1, exe_cond_pass=1, alu_nzcv=4'b0100, one edge -> status_reg=4'b0100 next cycle. Same with exe_cond_pass=0 and alu_nzcv=4'b1000 -> status_reg stays 4'b0100 and pending_cnt decrements.
- msr_we versus ALU: msr_we=1, msr_data=4'b0011, plus a valid ALU update with alu_nzcv=4'b1100 on the same edge -> status_reg=4'b0011.
- Counter range: four issues with id_set_flags=1, no EXE retire -> pending_cnt=3 and err_ovf=1. With id_uses_flags=1 -> flag_hazard=1. Three retires -> pending_cnt=0 and flag_hazard=0. One more retire -> err_udf=1.
- Freeze and flush: freeze=1 with valid update, alu_nzcv=4'b1111 -> no change. Then pending_cnt=2, flush=1 plus simultaneous issue -> pending_cnt=0.
- Asynchronous reset: rst asserted between edges while status_reg=4'b1010 -> status_reg=0 immediately, before the next edge.
- With STATUS_SHADOW_EN: status_reg=4'b0110, save. Then msr_data=4'b1001, then restore -> status_reg=4'b0110. save and restore together -> swap.
